// File: rtl/stage_if.sv
// Instruction-fetch stage: walks the PC, requests words from memory and presents them to IF/ID.
// Define ICACHE_EN to add a direct-mapped instruction cache of ICACHE_LINES lines in front of memory.
module stage_if #(
    parameter int ICACHE_LINES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [31:0] r_pc;
    logic [31:0] w_pc_n;
    logic [31:0] r_pc_o;
    logic [31:0] w_pc_o_n;
    logic [31:0] r_inst;
    logic [31:0] w_inst_n;
    logic        r_mem_req;
    logic        w_mem_req_n;
    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr_n;
    logic        r_discard;
    logic        w_discard_n;
    logic [31:0] w_target;
    logic        w_fill;
    logic        w_hit;
    logic [31:0] w_hit_word;

    assign w_target = jump_target_i & 32'hFFFF_FFFC;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             r_cache_data [ICACHE_LINES];
    logic [TAG_W-1:0]        r_cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] r_cache_valid;
    logic [IDX_W-1:0]        w_rd_idx;
    logic [IDX_W-1:0]        w_wr_idx;

    assign w_rd_idx   = r_pc[IDX_W+1:2];
    assign w_wr_idx   = r_mem_addr[IDX_W+1:2];
    assign w_hit      = r_cache_valid[w_rd_idx] && (r_cache_tag[w_rd_idx] == r_pc[31:IDX_W+2]);
    assign w_hit_word = r_cache_data[w_rd_idx];

    // Every returned word fills its line, even one whose fetch was discarded by a jump.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cache_valid <= '0;
        end else if (w_fill) begin
            r_cache_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_cache_data[w_wr_idx] <= mem_data_i;
            r_cache_tag[w_wr_idx]  <= r_mem_addr[31:IDX_W+2];
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_word = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_pc_o     <= '0;
            r_inst     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_pc_o     <= w_pc_o_n;
            r_inst     <= w_inst_n;
            r_mem_req  <= w_mem_req_n;
            r_mem_addr <= w_mem_addr_n;
            r_discard  <= w_discard_n;
        end
    end

    // A jump during WAIT cannot cancel the bus request, so it arms a discard for the returning word.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_pc_o_n     = r_pc_o;
        w_inst_n     = r_inst;
        w_mem_req_n  = r_mem_req;
        w_mem_addr_n = r_mem_addr;
        w_discard_n  = r_discard;
        w_fill       = 1'b0;

        case (r_state)
            IDLE: begin
                if (jump_i) begin
                    w_pc_n   = w_target;
                    w_inst_n = '0;
                end else if (w_hit) begin
                    w_inst_n  = w_hit_word;
                    w_pc_o_n  = r_pc;
                    w_state_n = VALID;
                end else begin
                    w_mem_req_n  = 1'b1;
                    w_mem_addr_n = r_pc;
                    w_state_n    = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    w_fill      = 1'b1;
                    w_mem_req_n = 1'b0;
                end
                if (jump_i) begin
                    w_pc_n = w_target;
                    if (mem_ack_i) begin
                        w_discard_n = 1'b0;
                        w_state_n   = IDLE;
                    end else begin
                        w_discard_n = 1'b1;
                    end
                end else if (mem_ack_i) begin
                    if (r_discard) begin
                        w_discard_n = 1'b0;
                        w_state_n   = IDLE;
                    end else begin
                        w_inst_n  = mem_data_i;
                        w_pc_o_n  = r_pc;
                        w_state_n = VALID;
                    end
                end
            end
            VALID: begin
                if (jump_i) begin
                    w_pc_n    = w_target;
                    w_inst_n  = '0;
                    w_state_n = IDLE;
                end else if (!stall_i) begin
                    w_pc_n    = r_pc + 32'd4;
                    w_inst_n  = '0;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign pc_o        = r_pc_o;
    assign inst_o      = r_inst;
    assign stall_req_o = (r_state != VALID);

endmodule
